// File: rtl/fp_sqrt64_ctrl.sv
// Sequencer for the iterative 64-bit square-root datapath. It screens special
// operands, halves the exponent and walks the external root step unit.
`ifndef FP_PREDEC_BITS
`define FP_PREDEC_BITS 8
`endif
`ifndef FP_STATE_BITS
`define FP_STATE_BITS 4
`endif
`ifndef FP_EXP_BITS
`define FP_EXP_BITS 11
`endif
`ifndef FP_MAN_BITS
`define FP_MAN_BITS 64
`endif

// state  | meaning
// S_IDLE | waiting for an operation, in_ready high
// S_ITER | step unit running, step_cnt = iteration index
// S_DONE | result presented on sqrtp_*, waiting for out_stall low
module fp_sqrt64_ctrl #(
    parameter int  ITERS    = 32,
    parameter int  EXP_BIAS = 1023,
    localparam int CNT_W    = $clog2(ITERS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       kill,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`FP_PREDEC_BITS-1:0] in_op_predec,
    input  logic [`FP_STATE_BITS-1:0]  in_state,
    input  logic [1:0]                 in_round,
    input  logic                       in_sign,
    input  logic [`FP_EXP_BITS-1:0]    in_exp,
    input  logic [`FP_MAN_BITS-1:0]    in_man,
    output logic                       step_start,
    output logic                       step_en,
    output logic [CNT_W-1:0]           step_cnt,
    output logic                       step_odd,
    output logic [`FP_MAN_BITS-1:0]    step_man,
    input  logic [`FP_MAN_BITS-1:0]    step_root,
    input  logic                       step_rem_nz,
    input  logic                       out_stall,
    output logic                       sqrtp_ready,
    output logic [`FP_PREDEC_BITS-1:0] sqrtp_op_predec,
    output logic [`FP_STATE_BITS-1:0]  sqrtp_state,
    output logic [1:0]                 sqrtp_round,
    output logic                       sqrtp_sign,
    output logic [`FP_EXP_BITS-1:0]    sqrtp_exp,
    output logic [`FP_MAN_BITS-1:0]    sqrtp_man
);
    localparam int PW = `FP_PREDEC_BITS;
    localparam int SW = `FP_STATE_BITS;
    localparam int EW = `FP_EXP_BITS;
    localparam int MW = `FP_MAN_BITS;
    localparam logic [MW-1:0] NAN_MAN = {2'b11, {(MW-2){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             odd_q, odd_d;
    logic [MW-1:0]    man_q, man_d;
    logic [PW-1:0]    predec_q, predec_d;
    logic [SW-1:0]    st_q, st_d;
    logic [1:0]       rnd_q, rnd_d;
    logic             sign_q, sign_d;
    logic [EW-1:0]    exp_q, exp_d;
    logic [MW-1:0]    res_q, res_d;

    logic              exp_zero, exp_ones, is_special, last_iter;
    logic signed [EW:0] e_unb;
    logic [EW-1:0]     res_exp;
    logic              spec_sign;
    logic [EW-1:0]     spec_exp;
    logic [MW-1:0]     spec_man;

    assign exp_zero   = (in_exp == '0);
    assign exp_ones   = (&in_exp);
    assign is_special = exp_zero | exp_ones | in_sign;
    assign last_iter  = (cnt_q == CNT_W'(ITERS - 1));

    // Unbiased exponent; the arithmetic shift floors odd negative values.
    assign e_unb   = $signed({1'b0, in_exp} - (EW+1)'(EXP_BIAS));
    assign res_exp = EW'(EXP_BIAS + int'(e_unb >>> 1));

    always_comb begin
        spec_sign = 1'b0;
        spec_exp  = '1;
        spec_man  = NAN_MAN;
        if (exp_zero) begin
            spec_sign = in_sign;
            spec_exp  = '0;
            spec_man  = '0;
        end else if (exp_ones && !(in_sign && in_man == '0)) begin
            spec_sign = in_sign;
            spec_exp  = in_exp;
            spec_man  = in_man;
        end
    end

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        odd_d    = odd_q;
        man_d    = man_q;
        predec_d = predec_q;
        st_d     = st_q;
        rnd_d    = rnd_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        res_d    = res_q;
        if (kill) begin
            fsm_d = S_IDLE;
        end else begin
            unique case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        cnt_d    = '0;
                        odd_d    = e_unb[0];
                        man_d    = in_man;
                        predec_d = in_op_predec;
                        st_d     = in_state;
                        rnd_d    = in_round;
                        if (is_special) begin
                            fsm_d  = S_DONE;
                            sign_d = spec_sign;
                            exp_d  = spec_exp;
                            res_d  = spec_man;
                        end else begin
                            fsm_d  = S_ITER;
                            sign_d = in_sign;
                            exp_d  = res_exp;
                        end
                    end
                end
                S_ITER: begin
                    if (last_iter) begin
                        fsm_d = S_DONE;
                        res_d = {step_root[MW-1:1], step_root[0] | step_rem_nz};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!out_stall) begin
                        fsm_d = S_IDLE;
                    end
                end
                default: fsm_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q    <= S_IDLE;
            cnt_q    <= '0;
            odd_q    <= 1'b0;
            man_q    <= '0;
            predec_q <= '0;
            st_q     <= '0;
            rnd_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            res_q    <= '0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            odd_q    <= odd_d;
            man_q    <= man_d;
            predec_q <= predec_d;
            st_q     <= st_d;
            rnd_q    <= rnd_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            res_q    <= res_d;
        end
    end

    // A flush in the same cycle keeps the step unit from advancing.
    assign in_ready   = (fsm_q == S_IDLE);
    assign step_en    = (fsm_q == S_ITER) && !kill;
    assign step_start = step_en && (cnt_q == '0);
    assign step_cnt   = cnt_q;
    assign step_odd   = odd_q;
    assign step_man   = man_q;

    assign sqrtp_ready     = (fsm_q == S_DONE);
    assign sqrtp_op_predec = predec_q;
    assign sqrtp_state     = st_q;
    assign sqrtp_round     = rnd_q;
    assign sqrtp_sign      = sign_q;
    assign sqrtp_exp       = exp_q;
    assign sqrtp_man       = res_q;

endmodule

// File: tb/tb_fp_sqrt64_ctrl.sv
// Randomized scoreboard bench for fp_sqrt64_ctrl: the driver queues expected
// results from an arithmetic reference model, a monitor checks each transfer.
`ifndef FP_PREDEC_BITS
`define FP_PREDEC_BITS 8
`endif
`ifndef FP_STATE_BITS
`define FP_STATE_BITS 4
`endif
`ifndef FP_EXP_BITS
`define FP_EXP_BITS 11
`endif
`ifndef FP_MAN_BITS
`define FP_MAN_BITS 64
`endif

module tb_fp_sqrt64_ctrl;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);
    localparam int PW = `FP_PREDEC_BITS;
    localparam int SW = `FP_STATE_BITS;
    localparam int EW = `FP_EXP_BITS;
    localparam int MW = `FP_MAN_BITS;
    localparam int EMAX = (1 << EW) - 1;
    localparam logic [MW-1:0] NAN_MAN = {2'b11, {(MW-2){1'b0}}};

    logic clk = 1'b0;
    logic reset, kill, in_valid, in_ready;
    logic [PW-1:0] in_op_predec;
    logic [SW-1:0] in_state;
    logic [1:0] in_round;
    logic in_sign;
    logic [EW-1:0] in_exp;
    logic [MW-1:0] in_man;
    logic step_start, step_en, step_odd;
    logic [CNT_W-1:0] step_cnt;
    logic [MW-1:0] step_man, step_root;
    logic step_rem_nz, out_stall, sqrtp_ready;
    logic [PW-1:0] sqrtp_op_predec;
    logic [SW-1:0] sqrtp_state;
    logic [1:0] sqrtp_round;
    logic sqrtp_sign;
    logic [EW-1:0] sqrtp_exp;
    logic [MW-1:0] sqrtp_man;

    fp_sqrt64_ctrl #(.ITERS(ITERS), .EXP_BIAS(1023)) dut (
        .clk(clk), .reset(reset), .kill(kill), .in_valid(in_valid), .in_ready(in_ready),
        .in_op_predec(in_op_predec), .in_state(in_state), .in_round(in_round),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
        .step_start(step_start), .step_en(step_en), .step_cnt(step_cnt), .step_odd(step_odd),
        .step_man(step_man), .step_root(step_root), .step_rem_nz(step_rem_nz),
        .out_stall(out_stall), .sqrtp_ready(sqrtp_ready), .sqrtp_op_predec(sqrtp_op_predec),
        .sqrtp_state(sqrtp_state), .sqrtp_round(sqrtp_round), .sqrtp_sign(sqrtp_sign),
        .sqrtp_exp(sqrtp_exp), .sqrtp_man(sqrtp_man)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [PW-1:0] predec;
        logic [SW-1:0] st;
        logic [1:0]    rnd;
        logic          sign;
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        logic [31:0]   rdy_cyc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: sqrt exponent is floor(unbiased/2) rebiased; specials by class.
    function automatic void model(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                                  output bit spec, output logic rs, output logic [EW-1:0] re,
                                  output logic [MW-1:0] rm, output logic odd);
        int eu;
        int lo;
        spec = 1'b1; odd = 1'b0; rs = s; re = e; rm = m;
        eu = int'(e) - 1023;
        lo = eu & 1;
        if (e == 0) begin
            rs = s; re = '0; rm = '0;
        end else if (int'(e) == EMAX && s && m == '0) begin
            rs = 1'b0; re = EW'(EMAX); rm = NAN_MAN;
        end else if (int'(e) == EMAX) begin
            rs = s; re = e; rm = m;
        end else if (s) begin
            rs = 1'b0; re = EW'(EMAX); rm = NAN_MAN;
        end else begin
            spec = 1'b0;
            odd = lo[0];
            rs = 1'b0;
            re = EW'(1023 + (eu - lo) / 2);
            rm = '0;
        end
    endfunction

    task automatic wait_idle();
        int w = 0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!in_ready) chk("idle_timeout", 64'(in_ready), 64'(1));
    endtask

    task automatic run_op(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m, output int acc);
        exp_t x;
        bit spec;
        logic odd, rs;
        logic [EW-1:0] re;
        logic [MW-1:0] rm, root;
        logic rem;
        int w = 0;
        root = '0; rem = 1'b0;
        while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'(1));
            acc = -1;
            return;
        end
        acc = cyc;
        model(s, e, m, spec, rs, re, rm, odd);
        x.predec = PW'($urandom);
        x.st = SW'($urandom);
        x.rnd = 2'($urandom);
        x.sign = rs; x.e = re; x.m = rm;
        x.rdy_cyc = 32'(acc + (spec ? 1 : ITERS + 1));
        in_op_predec = x.predec; in_state = x.st; in_round = x.rnd;
        in_sign = s; in_exp = e; in_man = m; in_valid = 1'b1;
        if (spec) sb.push_back(x);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (spec) begin
            chk("special_step_en", 64'(step_en), 64'(0));
        end else begin
            for (int i = 0; i < ITERS; i++) begin
                root = MW'({$urandom, $urandom});
                rem = 1'($urandom_range(0, 1));
                step_root = root; step_rem_nz = rem;
                chk("step_en", 64'(step_en), 64'(1));
                chk("step_cnt", 64'(step_cnt), 64'(i));
                chk("step_start", 64'(step_start), 64'(i == 0));
                if (i == 0) begin
                    chk("step_odd", 64'(step_odd), 64'(odd));
                    chk("step_man", 64'(step_man), 64'(m));
                end
                @(posedge clk); #1;
            end
            x.m = root | MW'(rem);
            sb.push_back(x);
        end
    endtask

    logic prev_rdy = 1'b0;
    int last_xfer = -10;
    always @(negedge clk) begin
        if (reset) begin
            prev_rdy <= 1'b0;
        end else begin
            if (sqrtp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 64'(sqrtp_ready), 64'(0));
                end else begin
                    if (!prev_rdy) chk("latency", 64'(cyc), 64'(sb[0].rdy_cyc));
                    chk("sqrtp_op_predec", 64'(sqrtp_op_predec), 64'(sb[0].predec));
                    chk("sqrtp_state", 64'(sqrtp_state), 64'(sb[0].st));
                    chk("sqrtp_round", 64'(sqrtp_round), 64'(sb[0].rnd));
                    chk("sqrtp_sign", 64'(sqrtp_sign), 64'(sb[0].sign));
                    chk("sqrtp_exp", 64'(sqrtp_exp), 64'(sb[0].e));
                    chk("sqrtp_man", 64'(sqrtp_man), 64'(sb[0].m));
                    chk("in_ready_in_done", 64'(in_ready), 64'(0));
                    if (!out_stall) begin
                        void'(sb.pop_front());
                        last_xfer <= cyc;
                    end
                end
            end
            prev_rdy <= sqrtp_ready;
        end
    end

    bit rand_stall = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rand_stall) out_stall = ($urandom_range(0, 2) == 0);
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sqrtp_ready"}, 64'(sqrtp_ready), 64'(0));
        chk({tag, "_step_en"}, 64'(step_en), 64'(0));
        chk({tag, "_step_start"}, 64'(step_start), 64'(0));
        chk({tag, "_step_cnt"}, 64'(step_cnt), 64'(0));
        chk({tag, "_step_odd"}, 64'(step_odd), 64'(0));
        chk({tag, "_step_man"}, 64'(step_man), 64'(0));
        chk({tag, "_sqrtp_fields"},
            64'({sqrtp_op_predec, sqrtp_state, sqrtp_round, sqrtp_sign, sqrtp_exp}), 64'(0));
        chk({tag, "_sqrtp_man"}, 64'(sqrtp_man), 64'(0));
    endtask

    initial begin
        int acc;
        int cls;
        int w;
        logic s;
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        reset = 1'b1; kill = 1'b0; in_valid = 1'b0; in_op_predec = '0; in_state = '0;
        in_round = '0; in_sign = 1'b0; in_exp = '0; in_man = '0; step_root = '0;
        step_rem_nz = 1'b0; out_stall = 1'b0;
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("in_ready_after_reset", 64'(in_ready), 64'(1));

        // basic normal op, then exponent halving cases
        run_op(1'b0, 11'd1024, 64'h8000_0000_0000_0000, acc);
        run_op(1'b0, 11'd1023, MW'({$urandom, $urandom}), acc);
        run_op(1'b0, 11'd1022, MW'({$urandom, $urandom}), acc);
        run_op(1'b0, 11'd1021, MW'({$urandom, $urandom}), acc);
        run_op(1'b0, 11'd1026, MW'({$urandom, $urandom}), acc);

        // specials
        run_op(1'b1, 11'd0, MW'({$urandom, $urandom}), acc);
        run_op(1'b0, 11'h7FF, '0, acc);
        run_op(1'b1, 11'd1000, MW'({$urandom, $urandom}), acc);
        run_op(1'b1, 11'h7FF, '0, acc);
        run_op(1'b1, 11'h7FF, 64'h0008_0000_0000_0001, acc);
        run_op(1'b0, 11'h7FF, 64'h4000_0000_0000_0000, acc);

        // stall hold, then back-to-back accept on release
        wait_idle();
        out_stall = 1'b1;
        run_op(1'b1, 11'd1000, MW'({$urandom, $urandom}), acc);
        repeat (5) begin @(posedge clk); #1; end
        chk("stall_ready_held", 64'(sqrtp_ready), 64'(1));
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        out_stall = 1'b0;
        run_op(1'b0, 11'd1030, MW'({$urandom, $urandom}), acc);
        chk("back_to_back_accept", 64'(acc), 64'(last_xfer + 1));

        // kill mid-iteration with a concurrent offer
        wait_idle();
        in_op_predec = 8'h5A; in_sign = 1'b0; in_exp = 11'd1100; in_man = MW'({$urandom, $urandom});
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        chk("kill_at_cnt", 64'(step_cnt), 64'(10));
        kill = 1'b1; in_valid = 1'b1; in_sign = 1'b1; in_exp = '0;
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        chk("kill_in_ready", 64'(in_ready), 64'(1));
        chk("kill_step_en", 64'(step_en), 64'(0));
        chk("kill_no_ready", 64'(sqrtp_ready), 64'(0));
        repeat (3) begin
            @(posedge clk); #1;
            chk("kill_idle_ready", 64'(in_ready), 64'(1));
        end
        kill = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; in_valid = 1'b0;
        chk("kill_idle_no_accept", 64'(in_ready), 64'(1));
        chk("kill_idle_no_ready", 64'(sqrtp_ready), 64'(0));
        run_op(1'b0, 11'd1050, MW'({$urandom, $urandom}), acc);

        // asynchronous reset between edges during iteration
        wait_idle();
        in_op_predec = 8'hA5; in_state = 4'h9; in_round = 2'b10;
        in_sign = 1'b0; in_exp = 11'd1024; in_man = 64'hDEAD_BEEF_0000_0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        chk("in_ready_after_mid_reset", 64'(in_ready), 64'(1));
        repeat (3) begin @(posedge clk); #1; end
        chk("no_ready_after_reset", 64'(sqrtp_ready), 64'(0));

        // randomized mix with random downstream stalls
        rand_stall = 1'b1;
        for (int n = 0; n < 40; n++) begin
            cls = int'($urandom_range(0, 9));
            s = 1'b0;
            e = EW'($urandom_range(1, EMAX - 1));
            m = MW'({$urandom, $urandom});
            case (cls)
                0: begin e = '0; s = 1'($urandom_range(0, 1)); end
                1: begin e = EW'(EMAX); s = 1'($urandom_range(0, 1)); if ($urandom_range(0, 1) == 0) m = '0; end
                2: s = 1'b1;
                default: ;
            endcase
            run_op(s, e, m, acc);
        end
        rand_stall = 1'b0;
        @(posedge clk); #2;
        out_stall = 1'b0;
        w = 0;
        while (sb.size() != 0 && w < 200) begin @(posedge clk); #1; w++; end
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
